// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared encodings and line levels for the UART transmit controller
package uart_tx_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_START  = S_START,
        ST_DATA   = S_DATA,
        ST_PARITY = S_PARITY,
        ST_STOP   = S_STOP
    } tx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic TX_IDLE_LVL  = 1'b1;
    localparam logic TX_START_LVL = 1'b0;
    localparam logic TX_STOP_LVL  = 1'b1;

endpackage

// File: rtl/parity_calc.sv
// rtl/parity_calc.sv - combinational even/odd parity of the frame data byte
module parity_calc
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  PAR_TYP,
    output logic                  par_bit
);

    assign par_bit = (PAR_TYP == PAR_ODD) ? ~(^P_DATA) : ^P_DATA;

endmodule

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit frame sequencer around the 8-bit serializer
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_done,
    input  logic                  ser_data,
    output logic                  ser_en,
    output logic                  Busy,
    output logic                  TX_OUT
);

    tx_state_e state, next_state;
    logic      par_bit_calc;
    logic      par_bit_q;
    logic      par_en_q;
    logic      tx_mux;
    logic      accept;

    parity_calc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity_calc (
        .P_DATA (P_DATA),
        .PAR_TYP(PAR_TYP),
        .par_bit(par_bit_calc)
    );

    // Busy is low in STOP as well, so a byte offered there starts the next frame back-to-back.
    assign accept = Data_Valid && !Busy;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= ST_IDLE;
            TX_OUT    <= TX_IDLE_LVL;
            par_bit_q <= 1'b0;
            par_en_q  <= 1'b0;
        end else begin
            state  <= next_state;
            TX_OUT <= tx_mux;
            if (accept) begin
                par_bit_q <= par_bit_calc;
                par_en_q  <= PAR_EN;
            end
        end
    end

    always_comb begin
        next_state = state;
        ser_en     = 1'b0;
        Busy       = 1'b0;
        tx_mux     = TX_IDLE_LVL;
        case (state)
            ST_IDLE: begin
                if (Data_Valid) next_state = ST_START;
            end
            ST_START: begin
                Busy       = 1'b1;
                tx_mux     = TX_START_LVL;
                next_state = ST_DATA;
            end
            ST_DATA: begin
                Busy   = 1'b1;
                ser_en = 1'b1;
                tx_mux = ser_data;
                if (ser_done) next_state = par_en_q ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                Busy       = 1'b1;
                tx_mux     = par_bit_q;
                next_state = ST_STOP;
            end
            ST_STOP: begin
                tx_mux     = TX_STOP_LVL;
                next_state = Data_Valid ? ST_START : ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - scoreboard bench for uart_tx_ctrl with an 8-bit serializer model
module tb_uart_tx_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       ser_done;
    logic       ser_data;
    logic       ser_en;
    logic       Busy;
    logic       TX_OUT;

    logic [7:0] sreg;
    logic [2:0] scnt;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int    cyc;
        logic  tx;
        logic  chk_busy;
        logic  busy;
        logic  sen;
        string tag;
    } exp_t;

    exp_t exp_q[$];

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .Data_Valid(Data_Valid),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .ser_done  (ser_done),
        .ser_data  (ser_data),
        .ser_en    (ser_en),
        .Busy      (Busy),
        .TX_OUT    (TX_OUT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Serializer: loads when the controller accepts a byte, shifts LSB first while enabled.
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sreg <= 8'h00;
            scnt <= 3'd0;
        end else if (Data_Valid && !Busy) begin
            sreg <= P_DATA;
            scnt <= 3'd0;
        end else if (ser_en) begin
            sreg <= {1'b0, sreg[7:1]};
            scnt <= scnt + 3'd1;
        end
    end

    assign ser_data = sreg[0];
    assign ser_done = ser_en && (scnt == 3'd7);

    task automatic push(input int c, input logic tx, input logic cb, input logic b,
                        input logic se, input string tag);
        exp_t e;
        e.cyc = c; e.tx = tx; e.chk_busy = cb; e.busy = b; e.sen = se; e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Offers a byte now; the expected line timeline is pushed for offsets 1..last_off.
    task automatic start_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                               input logic exp_par, input int last_off, input string tag,
                               output int k);
        int stop_off;
        P_DATA     = d;
        PAR_EN     = pen;
        PAR_TYP    = ptyp;
        Data_Valid = 1'b1;
        k          = cyc;
        stop_off   = pen ? 12 : 11;
        for (int o = 1; o <= stop_off && o <= last_off; o++) begin
            logic tx;
            logic b;
            if (o == 1)              tx = 1'b1;
            else if (o == 2)         tx = 1'b0;
            else if (o <= 10)        tx = d[o-3];
            else if (pen && o == 11) tx = exp_par;
            else                     tx = 1'b1;
            b = (o <= 9) || (pen && o == 10);
            push(k + o, tx, (o != stop_off), b, (o >= 2 && o <= 9), tag);
        end
    endtask

    always @(negedge CLK) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            if (e.cyc != cyc) begin
                n_tests++; n_fail++;
                $display("FAIL %s stale_item cyc=%0d now=%0d", e.tag, e.cyc, cyc);
            end else begin
                n_tests++;
                if (TX_OUT !== e.tx) begin
                    n_fail++;
                    $display("FAIL %s tx_out cyc=%0d got=%b exp=%b", e.tag, cyc, TX_OUT, e.tx);
                end
                n_tests++;
                if (ser_en !== e.sen) begin
                    n_fail++;
                    $display("FAIL %s ser_en cyc=%0d got=%b exp=%b", e.tag, cyc, ser_en, e.sen);
                end
                if (e.chk_busy) begin
                    n_tests++;
                    if (Busy !== e.busy) begin
                        n_fail++;
                        $display("FAIL %s busy cyc=%0d got=%b exp=%b", e.tag, cyc, Busy, e.busy);
                    end
                end
            end
        end
    end

    initial begin
        int k;
        RST        = 1'b1;
        Data_Valid = 1'b0;
        P_DATA     = 8'h00;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        #1 RST = 1'b0;
        for (int c = 1; c <= 3; c++) push(c, 1'b1, 1'b1, 1'b0, 1'b0, "reset");
        step(3);
        RST = 1'b1;

        for (int o = 1; o <= 20; o++) push(cyc + o, 1'b1, 1'b1, 1'b0, 1'b0, "idle");
        step(20);

        start_frame(8'hA5, 1'b0, 1'b0, 1'b0, 99, "a5_nopar", k);
        step(1); Data_Valid = 1'b0;
        step(12);

        start_frame(8'hA5, 1'b1, 1'b0, 1'b0, 99, "a5_even", k);
        step(1); Data_Valid = 1'b0;
        step(13);

        start_frame(8'hA5, 1'b1, 1'b1, 1'b1, 99, "a5_odd", k);
        step(1); Data_Valid = 1'b0;
        step(13);

        start_frame(8'h01, 1'b1, 1'b0, 1'b1, 99, "b2b_01", k);
        step(1); Data_Valid = 1'b0;
        step(10);
        start_frame(8'hFF, 1'b1, 1'b0, 1'b0, 99, "b2b_ff", k);
        step(1); Data_Valid = 1'b0;
        step(13);

        start_frame(8'h3C, 1'b1, 1'b1, 1'b1, 99, "midframe", k);
        step(1); P_DATA = 8'hFF; PAR_TYP = 1'b0;
        step(4); PAR_TYP = 1'b1;
        step(3); PAR_TYP = 1'b0; Data_Valid = 1'b0;
        step(6);

        start_frame(8'h55, 1'b0, 1'b0, 1'b0, 5, "pre_rst", k);
        step(1); Data_Valid = 1'b0;
        step(5);
        for (int o = 6; o <= 8; o++) push(k + o, 1'b1, 1'b1, 1'b0, 1'b0, "rst_mid");
        RST = 1'b0;
        step(2);
        RST = 1'b1;
        step(2);

        start_frame(8'h55, 1'b0, 1'b0, 1'b0, 99, "post_rst", k);
        step(1); Data_Valid = 1'b0;
        step(12);

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) step(1);
        if (exp_q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
